draw_bg_scroll: RTL and testbench
=================================

# draw_bg_scroll

Parametrised background renderer that replaces the fixed 4x-scaled background stage at the head of the VGA draw chain. It maps the raw timing position to a scaled, horizontally scrolling, wrap-around background address. It supports several background banks and a configurable ROM read latency. It delays the timing signals to match the ROM latency and drives the first `vga_if` stage with the background pixel, a fill colour below the image, or black during blanking.

## Interface
Parameters:
- `SCALE_SHIFT`, 2: screen-to-image downscale as a right shift applied to both `hcount` and `vcount`.
- `IMG_W`, 256: image width in source pixels; must be a power of two.
- `IMG_H`, 192: image height in source pixels; any value ≥ 1.
- `BANKS`, 2: number of backgrounds stored back-to-back in the ROM.
- `ROM_LATENCY`, 1: cycles from `bg_addr` change to valid `rgb_background`; range 0..4.
- `ADDR_W`, 20: width of `bg_addr`.
- `FILL_RGB`, 12'h000: colour for visible pixels below the image.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `hcount_in`, `vcount_in`  in  11 each  raw timing counters.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  raw timing flags.
- `scroll_en`  in  1  enables the per-frame offset update.
- `scroll_dir`  in  1  0 = image moves left (offset increases); 1 = image moves right (offset decreases).
- `scroll_speed`  in  4  source pixels per frame.
- `bank_sel`  in  $clog2(BANKS)  requested background bank.
- `rgb_background`  in  12  ROM data.
- `bg_addr`  out  ADDR_W  ROM address, registered.
- `scroll_offset`  out  $clog2(IMG_W)  current horizontal offset.
- `vga_out`  `vga_if.vga_out`  delayed timing plus rgb.

## Operation
- **Frame tick.** Single-cycle pulse on the `vblnk_in` rising edge. This requires a registered copy of `vblnk_in`, which resets to 0.
- **Offset update on tick.**
  - If `scroll_en`=1: `scroll_offset` ← (`scroll_offset` ± `scroll_speed`) mod `IMG_W`. Both directions wrap.
  - If `scroll_en`=0: the offset holds.
- **Bank latch.** `bank_sel` is latched into `bank_q` on the tick only. A change mid-frame never tears the picture.
- **Address stage** (registered):
  - sx = ((`hcount_in` >> `SCALE_SHIFT`) + `scroll_offset`) mod `IMG_W`, taken as the low bits.
  - sy = `vcount_in` >> `SCALE_SHIFT`.
  - `bg_addr` = `bank_q`·`IMG_W`·`IMG_H` + sy·`IMG_W` + sx.
  - If sy ≥ `IMG_H`: `bg_addr` = `bank_q`·`IMG_W`·`IMG_H`, and an `oob` flag is set and pipelined.
- **Delay line.** A shift register of depth 1+`ROM_LATENCY` carries hcount, vcount, hsync, vsync, hblnk, vblnk and `oob`.
- **Colour select** (final register):
  - Delayed hblnk or vblnk = 1 → 0.
  - Else delayed `oob` = 1 → `FILL_RGB`.
  - Else → `rgb_background`.
- **Reset.** All `vga_out` fields = 0, `bg_addr` = 0, `scroll_offset` = 0, `bank_q` = 0, delay line = 0.
- **Reset mid-frame.** The pipeline flushes; the first valid output follows latency L after `rst` falls. The offset restarts at 0.

## Timing
- Latency L = `ROM_LATENCY` + 2 cycles from the `*_in` signals to `vga_out`, identical for every field.
- `bg_addr` is valid 1 cycle after its input sample.
- Offset and bank updates take effect 1 cycle after the tick. They affect the address stage from the next input sample onward, which always falls inside vblank.
- Tick and `scroll_en`=1 with `scroll_speed`=0: the offset is unchanged (legal).
- `bank_sel` ≥ `BANKS`: latched value clamps to `BANKS`−1.

## Test plan
- **Static address.** Reset, `scroll_en`=0, `bank_sel`=0; drive hcount=8, vcount=4 → `bg_addr`=258 one cycle later; the matching `vga_out.rgb` equals `rgb_background` after L=3 cycles.
- **Scroll accumulate.** `scroll_en`=1, dir=0, speed=3 over 2 frame ticks → `scroll_offset`=6. Then hcount=0, vcount=0 → `bg_addr`=6.
- **Wrap both ways.**
  - Offset 254, speed 5, dir=0 → 3 after one tick.
  - Offset 2, speed 5, dir=1 → 253.
  - Offset 250 with hcount=40 (sx 10+250) → address low bits = 4.
- **Out of bounds and blanking.**
  - vcount=768 (sy=192 ≥ `IMG_H`), visible → rgb=`FILL_RGB`, not ROM data.
  - Any hblnk=1 cycle → rgb=0.
- **Bank latch.** `bank_sel` 0→1 mid-frame → addresses keep bank 0 until the next tick, then add 49152.
- **Reset mid-operation and latency sweep.**
  - Assert `rst` while scrolling → all outputs 0 the next cycle, offset 0.
  - Repeat the first scenario with `ROM_LATENCY`=0 and 3 → L=2 and L=5 respectively, with sync/blank alignment preserved.

Source files
------------

// File: rtl/vga_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_if                                                           |
// | Timing position, sync/blank flags and pixel colour passed        |
// | between stages of the VGA draw chain.                            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_bg_scroll.sv
`default_nettype none
// +------------------------------------------------------------------+
// | draw_bg_scroll                                                   |
// | Scaled, horizontally scrolling, wrap-around background renderer  |
// | with bank selection and a configurable ROM read latency.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module draw_bg_scroll #(
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned IMG_W       = 256,
   parameter int unsigned IMG_H       = 192,
   parameter int unsigned BANKS       = 2,
   parameter int unsigned ROM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 20,
   parameter logic [11:0] FILL_RGB    = 12'h000
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [10:0]                              hcount_in,
   input  logic [10:0]                              vcount_in,
   input  logic                                     hsync_in,
   input  logic                                     vsync_in,
   input  logic                                     hblnk_in,
   input  logic                                     vblnk_in,
   input  logic                                     scroll_en,
   input  logic                                     scroll_dir,
   input  logic [3:0]                               scroll_speed,
   input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] bank_sel,
   input  logic [11:0]                              rgb_background,
   output logic [ADDR_W-1:0]                        bg_addr,
   output logic [$clog2(IMG_W)-1:0]                 scroll_offset,
   vga_if.vga_out                                   vga_out
);

   localparam int unsigned c_OFS_W  = $clog2(IMG_W);
   localparam int unsigned c_BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int unsigned c_SUM_W  = (c_OFS_W > 4) ? c_OFS_W : 4;
   localparam int unsigned c_X_W    = (c_OFS_W > 11) ? c_OFS_W : 11;
   localparam int unsigned c_DEPTH  = ROM_LATENCY + 1;
   localparam logic [ADDR_W-1:0] c_BANK_SIZE = ADDR_W'(IMG_W * IMG_H);

   // Timing fields plus the out-of-image flag, carried alongside the ROM read
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic        oob;
   } tap_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } pix_t;

   logic                vblnk_prev_q, vblnk_prev_d;
   logic [c_OFS_W-1:0]  offset_q, offset_d;
   logic [c_BANK_W-1:0] bank_q, bank_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   tap_t                dly_q [c_DEPTH];
   tap_t                dly_d [c_DEPTH];
   pix_t                out_q, out_d;

   logic                w_tick;
   logic [c_BANK_W-1:0] w_bank_clamped;
   logic [c_SUM_W-1:0]  w_step_sum;
   logic [10:0]         w_hs;
   logic [10:0]         w_sy;
   logic [c_X_W-1:0]    w_xsum;
   logic [c_OFS_W-1:0]  w_sx;
   logic                w_oob;

   // One pulse per frame, on the rising edge of vertical blanking
   assign w_tick = vblnk_in & ~vblnk_prev_q;

   generate
      if ((1 << c_BANK_W) == BANKS) begin : g_bank_direct
         assign w_bank_clamped = bank_sel;
      end else begin : g_bank_clamp
         // Requests past the last bank select the last bank
         always_comb begin
            w_bank_clamped = bank_sel;
            if (32'(bank_sel) >= BANKS) w_bank_clamped = c_BANK_W'(BANKS - 1);
         end
      end
   endgenerate

   // Per-frame state: scroll offset (wraps modulo IMG_W) and bank latch
   always_comb begin
      vblnk_prev_d = vblnk_in;
      offset_d     = offset_q;
      bank_d       = bank_q;
      w_step_sum   = scroll_dir ? (c_SUM_W'(offset_q) - c_SUM_W'(scroll_speed))
                                : (c_SUM_W'(offset_q) + c_SUM_W'(scroll_speed));
      if (w_tick) begin
         if (scroll_en) offset_d = w_step_sum[c_OFS_W-1:0];
         bank_d = w_bank_clamped;
      end
   end

   // Address stage: scaled position, horizontal wrap, row-major bank layout
   always_comb begin
      w_hs   = hcount_in >> SCALE_SHIFT;
      w_sy   = vcount_in >> SCALE_SHIFT;
      w_xsum = c_X_W'(w_hs) + c_X_W'(offset_q);
      w_sx   = w_xsum[c_OFS_W-1:0];
      w_oob  = (32'(w_sy) >= IMG_H);
      addr_d = ADDR_W'(bank_q) * c_BANK_SIZE;
      if (!w_oob) addr_d = addr_d + (ADDR_W'(w_sy) << c_OFS_W) + ADDR_W'(w_sx);
   end

   // Delay line matching the address register plus the ROM latency
   always_comb begin
      dly_d[0].hcount = hcount_in;
      dly_d[0].vcount = vcount_in;
      dly_d[0].hsync  = hsync_in;
      dly_d[0].vsync  = vsync_in;
      dly_d[0].hblnk  = hblnk_in;
      dly_d[0].vblnk  = vblnk_in;
      dly_d[0].oob    = w_oob;
      for (int i = 1; i < int'(c_DEPTH); i++) dly_d[i] = dly_q[i-1];
   end

   // Colour select: blanking forces black, below the image uses the fill colour
   always_comb begin
      out_d.hcount = dly_q[c_DEPTH-1].hcount;
      out_d.vcount = dly_q[c_DEPTH-1].vcount;
      out_d.hsync  = dly_q[c_DEPTH-1].hsync;
      out_d.vsync  = dly_q[c_DEPTH-1].vsync;
      out_d.hblnk  = dly_q[c_DEPTH-1].hblnk;
      out_d.vblnk  = dly_q[c_DEPTH-1].vblnk;
      if (dly_q[c_DEPTH-1].hblnk || dly_q[c_DEPTH-1].vblnk) out_d.rgb = 12'h000;
      else if (dly_q[c_DEPTH-1].oob)                        out_d.rgb = FILL_RGB;
      else                                                  out_d.rgb = rgb_background;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev_q <= 1'b0;
         offset_q     <= '0;
         bank_q       <= '0;
         addr_q       <= '0;
         for (int i = 0; i < int'(c_DEPTH); i++) dly_q[i] <= '0;
         out_q        <= '0;
      end else begin
         vblnk_prev_q <= vblnk_prev_d;
         offset_q     <= offset_d;
         bank_q       <= bank_d;
         addr_q       <= addr_d;
         for (int i = 0; i < int'(c_DEPTH); i++) dly_q[i] <= dly_d[i];
         out_q        <= out_d;
      end
   end

   assign bg_addr        = addr_q;
   assign scroll_offset  = offset_q;
   assign vga_out.hcount = out_q.hcount;
   assign vga_out.vcount = out_q.vcount;
   assign vga_out.hsync  = out_q.hsync;
   assign vga_out.vsync  = out_q.vsync;
   assign vga_out.hblnk  = out_q.hblnk;
   assign vga_out.vblnk  = out_q.vblnk;
   assign vga_out.rgb    = out_q.rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_bg_scroll.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_draw_bg_scroll                                                |
// | Scoreboard bench: three instances (ROM latency 0, 1, 3) share    |
// | one stimulus stream checked against a behavioural model.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_draw_bg_scroll;

   localparam int          IMG_W = 256;
   localparam int          IMG_H = 192;
   localparam int          BANKS = 2;
   localparam int          SS    = 2;
   localparam logic [11:0] FILL  = 12'hA5C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [10:0] hc = '0, vc = '0;
   logic        hs = 0, vs = 0, hb = 0, vb = 0, en = 0, dir = 0;
   logic [3:0]  spd = '0;
   logic [0:0]  bsel = '0;

   logic [19:0] addr0, addr1, addr3;
   logic [7:0]  off0, off1, off3;
   logic [11:0] rgb0, rgb1, rgb3;
   logic [11:0] rom1_q;
   logic [11:0] rom3_q [3];

   vga_if vif0 ();
   vga_if vif1 ();
   vga_if vif3 ();

   // Pseudo ROM contents: a mix of address bits so neighbouring words differ
   function automatic logic [11:0] rom_f(input logic [19:0] a);
      return a[11:0] ^ {a[3:0], a[19:12]} ^ 12'h3C7;
   endfunction

   assign rgb0 = rom_f(addr0);
   always @(posedge clk) rom1_q <= rom_f(addr1);
   assign rgb1 = rom1_q;
   always @(posedge clk) begin
      rom3_q[0] <= rom_f(addr3);
      rom3_q[1] <= rom3_q[0];
      rom3_q[2] <= rom3_q[1];
   end
   assign rgb3 = rom3_q[2];

   draw_bg_scroll #(.ROM_LATENCY(0), .FILL_RGB(FILL)) dut0 (
      .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc),
      .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb),
      .scroll_en(en), .scroll_dir(dir), .scroll_speed(spd), .bank_sel(bsel),
      .rgb_background(rgb0), .bg_addr(addr0), .scroll_offset(off0), .vga_out(vif0));

   draw_bg_scroll #(.ROM_LATENCY(1), .FILL_RGB(FILL)) dut1 (
      .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc),
      .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb),
      .scroll_en(en), .scroll_dir(dir), .scroll_speed(spd), .bank_sel(bsel),
      .rgb_background(rgb1), .bg_addr(addr1), .scroll_offset(off1), .vga_out(vif1));

   draw_bg_scroll #(.ROM_LATENCY(3), .FILL_RGB(FILL)) dut3 (
      .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc),
      .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb),
      .scroll_en(en), .scroll_dir(dir), .scroll_speed(spd), .bank_sel(bsel),
      .rgb_background(rgb3), .bg_addr(addr3), .scroll_offset(off3), .vga_out(vif3));

   // One record per clock edge: the inputs sampled there and what they must produce
   typedef struct packed {
      int          edge_n;
      logic        rst;
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [19:0] addr;
      logic [7:0]  off;
      logic [11:0] rgb;
   } rec_t;

   rec_t sb[$];
   int   edge_n = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   // Reference model state
   int m_off  = 0;
   int m_bank = 0;
   bit m_prev = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic push_rec();
      rec_t r;
      int   sx, sy;
      bit   oob;
      r = '0;
      r.edge_n = edge_n + 1;
      r.rst    = rst;
      if (rst) begin
         m_off  = 0;
         m_bank = 0;
         m_prev = 0;
      end else begin
         r.hc = hc; r.vc = vc; r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb;
         sx  = (int'(hc) / (1 << SS) + m_off) % IMG_W;
         sy  = int'(vc) / (1 << SS);
         oob = (sy >= IMG_H);
         r.addr = 20'(m_bank * IMG_W * IMG_H + (oob ? 0 : sy * IMG_W + sx));
         if (hb || vb)  r.rgb = 12'h000;
         else if (oob)  r.rgb = FILL;
         else           r.rgb = rom_f(r.addr);
         if (vb && !m_prev) begin
            if (en) m_off = dir ? (m_off - int'(spd) + IMG_W) % IMG_W : (m_off + int'(spd)) % IMG_W;
            m_bank = (int'(bsel) >= BANKS) ? BANKS - 1 : int'(bsel);
         end
         m_prev = vb;
      end
      r.off = 8'(m_off);
      sb.push_back(r);
   endtask

   task automatic step();
      push_rec();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input int n, input logic [10:0] h, input logic [10:0] v, input logic vbl);
      for (int k = 0; k < n; k++) begin
         hc = h; vc = v; vb = vbl; hb = 1'b0;
         step();
      end
   endtask

   task automatic chk(input string nm, input int e, input logic [39:0] act, input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %h, expected %h", nm, e, act, exp);
      end
   endtask

   function automatic logic [39:0] exp_vga(input rec_t r);
      return 40'({r.hc, r.vc, r.hs, r.vs, r.hb, r.vb, r.rgb});
   endfunction

   // Index of the record that must be at a lane's output now, or -1 if a reset intervened
   function automatic int lane_idx(input int e, input int lat, input int base);
      int idx, last;
      idx  = e - lat + 1 - base;
      last = e - base;
      if (idx < 0) return -1;
      for (int j = idx; j <= last; j++) if (sb[j].rst) return -1;
      return idx;
   endfunction

   // Monitor: compares the DUT outputs every cycle against the scoreboard
   always @(negedge clk) begin : mon
      int   e, base, i, li;
      rec_t r;
      e = edge_n;
      if (e >= 1) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", e, 40'(sb.size()), 40'd1);
         end else begin
            base = sb[0].edge_n;
            i    = e - base;
            if (i < 0 || i >= sb.size()) begin
               chk("record_missing", e, 40'(i), 40'(sb.size() - 1));
            end else begin
               r = sb[i];
               chk("addr_l2", e, 40'(addr0), 40'(r.addr));
               chk("addr_l3", e, 40'(addr1), 40'(r.addr));
               chk("addr_l5", e, 40'(addr3), 40'(r.addr));
               chk("offset_l2", e, 40'(off0), 40'(r.off));
               chk("offset_l3", e, 40'(off1), 40'(r.off));
               chk("offset_l5", e, 40'(off3), 40'(r.off));
               if (r.rst) begin
                  chk("vga_rst_l2", e, 40'({vif0.hcount, vif0.vcount, vif0.hsync, vif0.vsync, vif0.hblnk, vif0.vblnk, vif0.rgb}), 40'd0);
                  chk("vga_rst_l3", e, 40'({vif1.hcount, vif1.vcount, vif1.hsync, vif1.vsync, vif1.hblnk, vif1.vblnk, vif1.rgb}), 40'd0);
                  chk("vga_rst_l5", e, 40'({vif3.hcount, vif3.vcount, vif3.hsync, vif3.vsync, vif3.hblnk, vif3.vblnk, vif3.rgb}), 40'd0);
               end
               li = lane_idx(e, 2, base);
               if (li >= 0) chk("vga_l2", e, 40'({vif0.hcount, vif0.vcount, vif0.hsync, vif0.vsync, vif0.hblnk, vif0.vblnk, vif0.rgb}), exp_vga(sb[li]));
               li = lane_idx(e, 3, base);
               if (li >= 0) chk("vga_l3", e, 40'({vif1.hcount, vif1.vcount, vif1.hsync, vif1.vsync, vif1.hblnk, vif1.vblnk, vif1.rgb}), exp_vga(sb[li]));
               li = lane_idx(e, 5, base);
               if (li >= 0) chk("vga_l5", e, 40'({vif3.hcount, vif3.vcount, vif3.hsync, vif3.vsync, vif3.hblnk, vif3.vblnk, vif3.rgb}), exp_vga(sb[li]));
            end
            while (sb.size() > 0 && sb[0].edge_n < e - 6) void'(sb.pop_front());
         end
      end
   end

   initial begin
      // Reset
      rst = 1'b1;
      for (int k = 0; k < 4; k++) step();
      rst = 1'b0;

      // Static address: (8,4) -> 258 on bank 0, no scrolling
      en = 1'b0; bsel = 1'b0;
      hold(6, 11'd8, 11'd4, 1'b0);

      // Scroll accumulate: two ticks at speed 3, then origin -> offset 6
      en = 1'b1; dir = 1'b0; spd = 4'd3;
      hold(3, 11'd0, 11'd0, 1'b1);
      hold(3, 11'd0, 11'd0, 1'b0);
      hold(3, 11'd0, 11'd0, 1'b1);
      en = 1'b0;
      hold(6, 11'd0, 11'd0, 1'b0);

      // Decrement wrap: 6 -> 1 -> 252
      en = 1'b1; dir = 1'b1; spd = 4'd5;
      for (int t = 0; t < 2; t++) begin
         hold(2, 11'd40, 11'd8, 1'b1);
         hold(4, 11'd40, 11'd8, 1'b0);
      end

      // Below the image, and a blanked pixel
      hold(4, 11'd100, 11'd768, 1'b0);
      hc = 11'd100; vc = 11'd20; hb = 1'b1; step();

      // Bank change mid-frame takes effect at the next tick only
      en = 1'b0; bsel = 1'b1;
      hold(4, 11'd12, 11'd12, 1'b0);
      hold(2, 11'd12, 11'd12, 1'b1);
      hold(4, 11'd12, 11'd12, 1'b0);

      // Randomised frames with occasional reset pulses
      for (int f = 0; f < 90; f++) begin
         int act, blk;
         act = $urandom_range(20, 60);
         blk = $urandom_range(2, 8);
         en  = ($urandom_range(0, 3) != 0);
         dir = 1'($urandom);
         spd = 4'($urandom);
         for (int k = 0; k < act + blk; k++) begin
            vb = (k >= act);
            hc = 11'($urandom_range(0, 1343));
            vc = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(740, 805)) : 11'($urandom_range(0, 805));
            hb = ($urandom_range(0, 7) == 0);
            hs = 1'($urandom);
            vs = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bsel = 1'($urandom);
            if ($urandom_range(0, 20) == 0) begin
               en  = 1'($urandom);
               dir = 1'($urandom);
               spd = 4'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
         end
      end

      rst = 1'b0; vb = 1'b0; hb = 1'b0;
      for (int k = 0; k < 10; k++) step();
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
